// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - shared MDU opcodes, WDsel read-out codes and op helpers
package e_mdu_pkg;

    // MDUop encodings driven by Control into the E-stage MDU.
    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    // WDsel codes for E-stage result selection; HI/LO feed mfhi/mflo.
    localparam logic [2:0] WD_ALU = 3'd0;
    localparam logic [2:0] WD_DM  = 3'd1;
    localparam logic [2:0] WD_PC8 = 3'd2;
    localparam logic [2:0] WD_HI  = 3'd3;
    localparam logic [2:0] WD_LO  = 3'd4;

    // True for the multi-cycle ops that occupy the unit.
    function automatic logic is_multicycle(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    // True for the divide ops, which use DIV_CYCLES latency.
    function automatic logic is_divide(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// rtl/e_mdu_arith.sv - combinational multiply/divide result for the MDU
//
// Ports:
//   op  : MDUop code
//   a   : rs operand (multiplicand / dividend)
//   b   : rt operand (multiplier / divisor)
//   hi  : upper product half or remainder
//   lo  : lower product half or quotient
//   wr  : result should be committed (low for divide by zero and non-arith ops)
module mdu_arith
    import e_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             wr
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic        [WIDTH-1:0]   b_safe;
    logic signed [WIDTH-1:0]   quot_s;
    logic signed [WIDTH-1:0]   rem_s;
    logic        [WIDTH-1:0]   quot_u;
    logic        [WIDTH-1:0]   rem_u;
    logic                      b_zero;
    logic                      div_ovf;

    // Operands are widened first so the product is formed at full width.
    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // A zero divisor is replaced so the divider never sees it; the
    // result is discarded via wr anyway.
    assign b_zero  = (b == '0);
    assign b_safe  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    assign div_ovf = (a == MOST_NEG) && (b == '1);

    // Native signed / and % truncate toward zero with the remainder
    // following the dividend, which is the required architectural rule.
    assign quot_s = $signed(a) / $signed(b_safe);
    assign rem_s  = $signed(a) % $signed(b_safe);
    assign quot_u = a / b_safe;
    assign rem_u  = a % b_safe;

    always_comb begin
        hi = '0;
        lo = '0;
        wr = 1'b0;
        case (op)
            MDU_MULT: begin
                {hi, lo} = prod_s;
                wr       = 1'b1;
            end
            MDU_MULTU: begin
                {hi, lo} = prod_u;
                wr       = 1'b1;
            end
            MDU_DIV: begin
                if (div_ovf) begin
                    lo = a;
                    hi = '0;
                end else begin
                    lo = quot_s;
                    hi = rem_s;
                end
                wr = !b_zero;
            end
            MDU_DIVU: begin
                lo = quot_u;
                hi = rem_u;
                wr = !b_zero;
            end
            default: begin
                hi = '0;
                lo = '0;
                wr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multi-cycle multiply/divide unit with HI/LO registers
//
// Ports:
//   Clk, Reset : clock, synchronous active-high reset
//   Start      : one-cycle launch pulse for MULT/MULTU/DIV/DIVU
//   MDUop      : operation code (see e_mdu_pkg)
//   A, B       : forwarded rs / rt values
//   Busy       : an operation is in flight
//   HI, LO     : architectural HI/LO registers
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       MDUop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             wr_q;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             res_wr;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op (MDUop),
        .a  (A),
        .b  (B),
        .hi (res_hi),
        .lo (res_lo),
        .wr (res_wr)
    );

    // The result is computed at launch and parked in hi_q/lo_q; HI/LO
    // only move when the counter expires, so mfhi/mflo never observe a
    // partial or early result.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Busy <= 1'b0;
            cnt  <= '0;
            hi_q <= '0;
            lo_q <= '0;
            wr_q <= 1'b0;
            HI   <= '0;
            LO   <= '0;
        end else if (Busy) begin
            if (cnt == CNT_ONE) begin
                Busy <= 1'b0;
                cnt  <= '0;
                if (wr_q) begin
                    HI <= hi_q;
                    LO <= lo_q;
                end
            end else begin
                cnt <= cnt - CNT_ONE;
            end
        end else if (Start && is_multicycle(MDUop)) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
            wr_q <= res_wr;
            cnt  <= is_divide(MDUop) ? DIV_LAT : MULT_LAT;
            Busy <= 1'b1;
        end else if (MDUop == MDU_MTHI) begin
            HI <= A;
        end else if (MDUop == MDU_MTLO) begin
            LO <= A;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - self-checking bench for e_mdu with a behavioural model
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  MDUop;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO;

    logic        s_start;
    logic [2:0]  s_op;
    logic [31:0] s_a, s_b;
    logic        s_busy;
    logic [31:0] s_hi, s_lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi, exp_lo;

    always #5 Clk = ~Clk;

    e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .MDUop(MDUop),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    e_mdu #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(s_start), .MDUop(s_op),
        .A(s_a), .B(s_b), .Busy(s_busy), .HI(s_hi), .LO(s_lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: arithmetic on 64-bit integers from the architectural rules.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic wr, output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, ma, mb, q, r, p;
        longint unsigned pu;
        wr = 1'b1; h = 32'h0; l = 32'h0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MDU_MULT: begin
                p = sa * sb;
                h = p[63:32]; l = p[31:0];
            end
            MDU_MULTU: begin
                pu = {32'h0, a} * {32'h0, b};
                h = pu[63:32]; l = pu[31:0];
            end
            MDU_DIV: begin
                if (b == 0) wr = 1'b0;
                else begin
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    q = ma / mb;
                    r = ma % mb;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    if (sa < 0) r = -r;
                    h = r[31:0]; l = q[31:0];
                end
            end
            MDU_DIVU: begin
                if (b == 0) wr = 1'b0;
                else begin
                    h = a % b; l = a / b;
                end
            end
            default: wr = 1'b0;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int n;
        logic wr;
        logic [31:0] h, l;
        n = (op == MDU_DIV || op == MDU_DIVU) ? 10 : 5;
        model(op, a, b, wr, h, l);
        @(negedge Clk);
        Start = 1'b1; MDUop = op; A = a; B = b;
        @(posedge Clk); #1;
        Start = 1'b0; MDUop = MDU_NONE;
        check({tag, "_busy1"}, {31'b0, Busy}, 32'd1);
        for (int i = 2; i <= n; i++) begin
            @(posedge Clk); #1;
            check({tag, "_busy"}, {31'b0, Busy}, 32'd1);
            check({tag, "_hold_hi"}, HI, exp_hi);
        end
        if (wr) begin
            exp_hi = h;
            exp_lo = l;
        end
        @(posedge Clk); #1;
        check({tag, "_idle"}, {31'b0, Busy}, 32'd0);
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
    endtask

    task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] a);
        @(negedge Clk);
        MDUop = op; A = a;
        @(posedge Clk); #1;
        MDUop = MDU_NONE;
        if (op == MDU_MTHI) exp_hi = a;
        else exp_lo = a;
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
        check({tag, "_busy"}, {31'b0, Busy}, 32'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        Reset = 1'b1; Start = 1'b0; MDUop = MDU_NONE; A = 0; B = 0;
        s_start = 1'b0; s_op = MDU_NONE; s_a = 0; s_b = 0;
        exp_hi = 0; exp_lo = 0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;

        run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_neg_hi_c", HI, 32'hFFFF_FFFF);
        check("mult_neg_lo_c", LO, 32'hFFFF_FFFA);
        run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
        check("multu_hi_c", HI, 32'h0000_0001);
        check("multu_lo_c", LO, 32'hFFFF_FFFE);
        run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_lo_c", LO, 32'hFFFF_FFFD);
        check("div_neg_hi_c", HI, 32'hFFFF_FFFF);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo_c", LO, 32'h8000_0000);
        check("div_ovf_hi_c", HI, 32'h0);

        move_to("mthi", MDU_MTHI, 32'h1234);
        move_to("mtlo", MDU_MTLO, 32'h5678);
        run_op("divu_zero", MDU_DIVU, 32'd99, 32'd0);
        check("divu_zero_hi_c", HI, 32'h1234);
        check("divu_zero_lo_c", LO, 32'h5678);

        // Start with a non-launching op must leave the unit idle.
        @(negedge Clk);
        Start = 1'b1; MDUop = 3'd7; A = 32'h55; B = 32'h3;
        @(posedge Clk); #1;
        Start = 1'b0; MDUop = MDU_NONE;
        check("nop_busy", {31'b0, Busy}, 32'd0);
        check("nop_lo", LO, exp_lo);

        // Start and MTLO during an in-flight MULT are ignored.
        @(negedge Clk);
        Start = 1'b1; MDUop = MDU_MULT; A = 32'd2; B = 32'd2;
        @(posedge Clk); #1;
        Start = 1'b0; MDUop = MDU_NONE;
        check("ign_busy1", {31'b0, Busy}, 32'd1);
        @(negedge Clk);
        Start = 1'b1; MDUop = MDU_DIVU; A = 32'd7; B = 32'd3;
        @(posedge Clk); #1;
        Start = 1'b0; MDUop = MDU_NONE;
        check("ign_busy2", {31'b0, Busy}, 32'd1);
        @(negedge Clk);
        MDUop = MDU_MTLO; A = 32'd9;
        @(posedge Clk); #1;
        MDUop = MDU_NONE;
        check("ign_busy3", {31'b0, Busy}, 32'd1);
        check("ign_lo_mid", LO, exp_lo);
        repeat (2) begin
            @(posedge Clk); #1;
            check("ign_busy", {31'b0, Busy}, 32'd1);
        end
        @(posedge Clk); #1;
        exp_hi = 32'd0; exp_lo = 32'd4;
        check("ign_idle", {31'b0, Busy}, 32'd0);
        check("ign_lo", LO, exp_lo);
        check("ign_hi", HI, exp_hi);
        @(posedge Clk); #1;
        check("ign_nolaunch", {31'b0, Busy}, 32'd0);

        // Reset in busy cycle 3 aborts the op.
        move_to("pre_rst_hi", MDU_MTHI, 32'hA5A5_0001);
        @(negedge Clk);
        Start = 1'b1; MDUop = MDU_MULT; A = 32'd2; B = 32'd2;
        @(posedge Clk); #1;
        Start = 1'b0; MDUop = MDU_NONE;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        exp_hi = 0; exp_lo = 0;
        check("abort_busy", {31'b0, Busy}, 32'd0);
        check("abort_hi", HI, exp_hi);
        check("abort_lo", LO, exp_lo);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        check("abort_later_busy", {31'b0, Busy}, 32'd0);
        check("abort_later_hi", HI, exp_hi);
        check("abort_later_lo", LO, exp_lo);

        // Randomized ops against the model.
        for (int k = 0; k < 24; k++) begin
            rop = 3'($urandom_range(1, 6));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            if (rop == MDU_MTHI || rop == MDU_MTLO) move_to("rnd_mt", rop, ra);
            else run_op("rnd", rop, ra, rb);
        end

        // Single-cycle latency instance.
        @(negedge Clk);
        s_start = 1'b1; s_op = MDU_MULT; s_a = 32'd3; s_b = 32'd5;
        @(posedge Clk); #1;
        s_start = 1'b0; s_op = MDU_NONE;
        check("sw_mult_busy", {31'b0, s_busy}, 32'd1);
        check("sw_mult_lo_old", s_lo, 32'd0);
        @(posedge Clk); #1;
        check("sw_mult_idle", {31'b0, s_busy}, 32'd0);
        check("sw_mult_lo", s_lo, 32'd15);
        check("sw_mult_hi", s_hi, 32'd0);
        @(negedge Clk);
        s_start = 1'b1; s_op = MDU_DIV; s_a = 32'd7; s_b = 32'hFFFF_FFFE;
        @(posedge Clk); #1;
        s_start = 1'b0; s_op = MDU_NONE;
        check("sw_div_busy", {31'b0, s_busy}, 32'd1);
        @(posedge Clk); #1;
        check("sw_div_idle", {31'b0, s_busy}, 32'd0);
        check("sw_div_lo", s_lo, 32'hFFFF_FFFD);
        check("sw_div_hi", s_hi, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
